// File: rtl/vect_quad_fold.sv
// Quadrant pre-fold and angle post-correction around a vectoring CORDIC pipeline.
// Left-half-plane vectors are rotated by 180 degrees on entry, and the full-circle angle is restored on exit.
module vect_quad_fold #(
    parameter int N      = 16,
    parameter int STAGE  = 16,
    parameter int ANG_PI = 18000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] x_in,
    input  logic [N-1:0] y_in,
    output logic [N-1:0] x_fold,
    output logic [N-1:0] y_fold,
    input  logic [N-1:0] r_pipe,
    input  logic [N-1:0] ang_pipe,
    output logic         out_valid,
    output logic [N-1:0] r_out,
    output logic [N-1:0] angle_out,
    output logic [1:0]   quad_out
);

    typedef struct packed {
        logic       valid;
        logic       flip;
        logic [1:0] quad;
    } tag_t;

    localparam logic [N-1:0]        MOST_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]        MOST_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N:0]   PI_W     = (N+1)'(ANG_PI);
    localparam logic signed [N:0]   TWO_PI_W = (N+1)'(2 * ANG_PI);

    // The most negative code has no positive twin, so it clamps to full scale.
    function automatic logic [N-1:0] neg_sat(input logic [N-1:0] v);
        if (v == MOST_NEG) begin
            return MOST_POS;
        end
        return (~v) + 1'b1;
    endfunction

    logic         in_flip;
    logic [1:0]   in_quad;
    logic [N-1:0] x_fold_d;
    logic [N-1:0] y_fold_d;

    always_comb begin
        in_flip  = x_in[N-1];
        in_quad  = {y_in[N-1], x_in[N-1] ^ y_in[N-1]};
        x_fold_d = in_flip ? neg_sat(x_in) : x_in;
        y_fold_d = in_flip ? neg_sat(y_in) : y_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_fold <= '0;
            y_fold <= '0;
        end else if (in_valid) begin
            x_fold <= x_fold_d;
            y_fold <= y_fold_d;
        end
    end

    // The tag travels alongside x_fold, then through a line as deep as the pipeline.
    tag_t tag_fold;
    tag_t tag_line [STAGE];
    tag_t tag_tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_fold <= '0;
        end else begin
            tag_fold <= {in_valid, in_flip, in_quad};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGE; i++) begin
                tag_line[i] <= '0;
            end
        end else begin
            tag_line[0] <= tag_fold;
            for (int i = 1; i < STAGE; i++) begin
                tag_line[i] <= tag_line[i-1];
            end
        end
    end

    assign tag_tail = tag_line[STAGE-1];

    logic signed [N:0] ang_ext;
    logic signed [N:0] ang_sum;
    logic [N-1:0]      angle_corr;

    // One extra bit keeps the +/-180 offset from overflowing before the wrap.
    always_comb begin
        ang_ext = {ang_pipe[N-1], ang_pipe};
        ang_sum = ang_ext;
        if (tag_tail.flip) begin
            if (tag_tail.quad == 2'd1) begin
                ang_sum = ang_ext + PI_W;
            end else if (tag_tail.quad == 2'd2) begin
                ang_sum = ang_ext - PI_W;
            end
        end
        angle_corr = N'(ang_sum);
        if (ang_sum > PI_W) begin
            angle_corr = N'(ang_sum - TWO_PI_W);
        end else if (ang_sum <= -PI_W) begin
            angle_corr = N'(ang_sum + TWO_PI_W);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            r_out     <= '0;
            angle_out <= '0;
            quad_out  <= '0;
        end else begin
            out_valid <= tag_tail.valid;
            if (tag_tail.valid) begin
                r_out     <= r_pipe;
                angle_out <= angle_corr;
                quad_out  <= tag_tail.quad;
            end
        end
    end

endmodule

// File: tb/tb_vect_quad_fold.sv
// Bench for vect_quad_fold: a stand-in pipeline feeds ideal or random angles,
// and a cycle-indexed history predicts every output from the angle rules.
module tb_vect_quad_fold;

    localparam int N      = 16;
    localparam int STAGE  = 16;
    localparam int ANG_PI = 18000;
    localparam int HIST   = 4096;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic [N-1:0] x_in = '0;
    logic [N-1:0] y_in = '0;
    logic [N-1:0] x_fold, y_fold;
    logic [N-1:0] r_pipe, ang_pipe;
    logic         out_valid;
    logic [N-1:0] r_out, angle_out;
    logic [1:0]   quad_out;

    vect_quad_fold #(.N(N), .STAGE(STAGE), .ANG_PI(ANG_PI)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x_in(x_in), .y_in(y_in), .x_fold(x_fold), .y_fold(y_fold),
        .r_pipe(r_pipe), .ang_pipe(ang_pipe),
        .out_valid(out_valid), .r_out(r_out), .angle_out(angle_out), .quad_out(quad_out)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic int ideal_ang(input logic [15:0] xf, input logic [15:0] yf);
        int  xs, ys;
        real v;
        xs = $signed(xf);
        ys = $signed(yf);
        if (xs == 0 && ys == 0) return 0;
        v = $atan2(real'(ys), real'(xs)) * 18000.0 / 3.141592653589793;
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

    function automatic int ideal_mag(input logic [15:0] xf, input logic [15:0] yf);
        real xr, yr, m;
        xr = $signed(xf);
        yr = $signed(yf);
        m  = $sqrt(xr * xr + yr * yr);
        if (m > 32767.0) m = 32767.0;
        return $rtoi(m + 0.5);
    endfunction

    function automatic int quad_of(input logic [15:0] x, input logic [15:0] y);
        int xs, ys;
        xs = $signed(x);
        ys = $signed(y);
        if (xs >= 0 && ys >= 0) return 0;
        if (xs < 0 && ys >= 0) return 1;
        if (xs < 0 && ys < 0) return 2;
        return 3;
    endfunction

    function automatic logic [15:0] fold_val(input logic [15:0] x, input logic [15:0] v);
        int s;
        s = $signed(v);
        if ($signed(x) < 0) s = -s;
        if (s > 32767) s = 32767;
        return 16'(s);
    endfunction

    function automatic logic [15:0] corr(input logic [15:0] a, input logic [15:0] x, input logic [15:0] y);
        int v, q;
        v = $signed(a);
        q = quad_of(x, y);
        if ($signed(x) < 0) v = v + ((q == 1) ? ANG_PI : -ANG_PI);
        if (v > ANG_PI) v = v - 2 * ANG_PI;
        else if (v <= -ANG_PI) v = v + 2 * ANG_PI;
        return 16'(v);
    endfunction

    // Stand-in pipeline: mode 0 ideal atan2/magnitude, 1 random, 2 constant angle.
    int           pmode = 0;
    int           const_a = 0;
    logic [N-1:0] rnd_r = '0, rnd_a = '0;
    logic [N-1:0] inj_r, inj_a;
    logic [N-1:0] pipe_r [STAGE];
    logic [N-1:0] pipe_a [STAGE];

    always @(negedge clk) begin
        rnd_r <= 16'($urandom);
        rnd_a <= 16'($urandom);
    end

    always_comb begin
        inj_r = rnd_r;
        inj_a = rnd_a;
        if (pmode == 0) begin
            inj_r = 16'(ideal_mag(x_fold, y_fold));
            inj_a = 16'(ideal_ang(x_fold, y_fold));
        end else if (pmode == 2) begin
            inj_a = 16'(const_a);
        end
    end

    always @(posedge clk) begin
        pipe_r[0] <= inj_r;
        pipe_a[0] <= inj_a;
        for (int i = 1; i < STAGE; i++) begin
            pipe_r[i] <= pipe_r[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign r_pipe   = pipe_r[STAGE-1];
    assign ang_pipe = pipe_a[STAGE-1];

    // Reference: output after edge c comes from the input at edge c-STAGE-1
    // and the angle that entered the pipeline at edge c-STAGE.
    int           cyc = 0;
    logic         hv [HIST];
    logic [N-1:0] hx [HIST];
    logic [N-1:0] hy [HIST];
    logic [N-1:0] hr [HIST];
    logic [N-1:0] ha [HIST];
    logic         exp_v = 1'b0;
    logic [N-1:0] exp_r = '0, exp_a = '0, exp_xf = '0, exp_yf = '0;
    logic [1:0]   exp_q = '0;

    always @(posedge clk) begin
        hv[cyc % HIST] <= rst & in_valid;
        hx[cyc % HIST] <= x_in;
        hy[cyc % HIST] <= y_in;
        hr[cyc % HIST] <= inj_r;
        ha[cyc % HIST] <= inj_a;
        if (!rst) begin
            for (int i = 0; i < HIST; i++) hv[i] <= 1'b0;
            exp_v  <= 1'b0;
            exp_r  <= '0;
            exp_a  <= '0;
            exp_q  <= '0;
            exp_xf <= '0;
            exp_yf <= '0;
        end else begin
            if (in_valid) begin
                exp_xf <= fold_val(x_in, x_in);
                exp_yf <= fold_val(x_in, y_in);
            end
            if (cyc >= STAGE + 1 && hv[(cyc - STAGE - 1) % HIST]) begin
                exp_v <= 1'b1;
                exp_r <= hr[(cyc - STAGE) % HIST];
                exp_a <= corr(ha[(cyc - STAGE) % HIST], hx[(cyc - STAGE - 1) % HIST], hy[(cyc - STAGE - 1) % HIST]);
                exp_q <= 2'(quad_of(hx[(cyc - STAGE - 1) % HIST], hy[(cyc - STAGE - 1) % HIST]));
            end else begin
                exp_v <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic check_output(input string name, input bit ok, input int got, input int want);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic stream_check();
        check_output("out_valid", out_valid == exp_v, int'(out_valid), int'(exp_v));
        check_output("r_out", r_out == exp_r, $signed(r_out), $signed(exp_r));
        check_output("angle_out", angle_out == exp_a, $signed(angle_out), $signed(exp_a));
        check_output("quad_out", quad_out == exp_q, int'(quad_out), int'(exp_q));
        check_output("x_fold", x_fold == exp_xf, $signed(x_fold), $signed(exp_xf));
        check_output("y_fold", y_fold == exp_yf, $signed(y_fold), $signed(exp_yf));
    endtask

    task automatic apply_stimulus(input logic v, input logic [N-1:0] x, input logic [N-1:0] y);
        in_valid = v;
        x_in     = x;
        y_in     = y;
        @(posedge clk);
        @(negedge clk);
        stream_check();
    endtask

    function automatic logic [N-1:0] rnd16();
        if ($urandom_range(15) == 0) return 16'h8000;
        return 16'($urandom);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    typedef struct {
        int x, y, xf, yf, ang, q, r, tol, pm, ca;
    } vec_t;

    vec_t vecs[$];
    bit   pat [7];
    int   lat;
    int   got_a;

    initial begin
        // x, y, x_fold, y_fold, angle, quad, r, tolerance, pipe mode, constant angle
        vecs.push_back('{1000, 0, 1000, 0, 0, 0, 1000, 20, 0, 0});
        vecs.push_back('{-1000, 0, 1000, 0, 18000, 1, 1000, 20, 0, 0});
        vecs.push_back('{-1000, -1000, 1000, 1000, -13500, 2, 1414, 20, 0, 0});
        vecs.push_back('{1000, -1000, 1000, -1000, -4500, 3, 1414, 20, 0, 0});
        vecs.push_back('{-32768, 0, 32767, 0, 18000, 1, 32767, 20, 0, 0});
        vecs.push_back('{0, 1000, 0, 1000, 9000, 0, 1000, 20, 0, 0});
        vecs.push_back('{-1000, 1000, 1000, -1000, 13500, 1, 1414, 20, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 20, 0, 0});
        vecs.push_back('{-5, 3, 5, -3, -17970, 1, 0, 0, 2, 30});
        vecs.push_back('{5, 3, 5, 3, 18000, 0, 0, 0, 2, -18000});
        vecs.push_back('{-5, -3, 5, 3, 17900, 2, 0, 0, 2, -100});
        pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b0;
        repeat (3) apply_stimulus(1'b0, '0, '0);
        check_output("rst_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check_output("rst_angle", angle_out == '0, $signed(angle_out), 0);
        check_output("rst_r", r_out == '0, $signed(r_out), 0);
        check_output("rst_x_fold", x_fold == '0, $signed(x_fold), 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            pmode   = vecs[i].pm;
            const_a = vecs[i].ca;
            apply_stimulus(1'b1, 16'(vecs[i].x), 16'(vecs[i].y));
            check_output("dir_x_fold", $signed(x_fold) == vecs[i].xf, $signed(x_fold), vecs[i].xf);
            check_output("dir_y_fold", $signed(y_fold) == vecs[i].yf, $signed(y_fold), vecs[i].yf);
            repeat (STAGE) apply_stimulus(1'b0, '0, '0);
            check_output("dir_early", out_valid == 1'b0, int'(out_valid), 0);
            apply_stimulus(1'b0, '0, '0);
            got_a = $signed(angle_out);
            check_output("dir_valid", out_valid == 1'b1, int'(out_valid), 1);
            check_output("dir_angle", iabs(got_a - vecs[i].ang) <= vecs[i].tol, got_a, vecs[i].ang);
            check_output("dir_quad", int'(quad_out) == vecs[i].q, int'(quad_out), vecs[i].q);
            if (vecs[i].pm == 0)
                check_output("dir_r", iabs($signed(r_out) - vecs[i].r) * 50 <= vecs[i].r, $signed(r_out), vecs[i].r);
            apply_stimulus(1'b0, '0, '0);
            check_output("dir_pulse", out_valid == 1'b0, int'(out_valid), 0);
        end

        pmode = 1;
        for (int k = 0; k < STAGE + 8; k++) begin
            if (k < 7) apply_stimulus(pat[k], rnd16(), rnd16());
            else apply_stimulus(1'b0, '0, '0);
            if (k >= STAGE + 1)
                check_output("pattern", out_valid == pat[k-STAGE-1], int'(out_valid), int'(pat[k-STAGE-1]));
        end

        repeat (STAGE + 3) apply_stimulus(1'b1, rnd16(), rnd16());
        rst = 1'b0;
        #1;
        check_output("async_out_valid", out_valid == 1'b0, int'(out_valid), 0);
        check_output("async_x_fold", x_fold == '0, $signed(x_fold), 0);
        check_output("async_angle", angle_out == '0, $signed(angle_out), 0);
        apply_stimulus(1'b1, rnd16(), rnd16());
        rst = 1'b1;
        for (int k = 0; k < STAGE + 4; k++) begin
            apply_stimulus(1'b0, '0, '0);
            check_output("rst_drop", out_valid == 1'b0, int'(out_valid), 0);
        end
        apply_stimulus(1'b1, 16'd700, 16'hfe00);
        lat = 1;
        while (!out_valid && lat < 3 * STAGE) begin
            apply_stimulus(1'b0, '0, '0);
            lat++;
        end
        check_output("rst_latency", lat == STAGE + 2, lat, STAGE + 2);

        for (int k = 0; k < 600; k++) begin
            pmode = (k < 300) ? 1 : 0;
            apply_stimulus(1'($urandom_range(3) != 0), rnd16(), rnd16());
        end
        repeat (STAGE + 3) apply_stimulus(1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vect_quad_fold.md
# vect_quad_fold

Quadrant pre-fold and angle post-correction stage wrapped around the vectoring CORDIC pipeline. On the upstream side it registers each input vector and folds left-half-plane vectors by 180° into the pipeline's convergence range (|angle| ≤ 99.7°), recording the quadrant. On the downstream side it takes the pipeline's magnitude and angle STAGE cycles later and restores the full-circle angle. It also carries a valid flag and quadrant tag through a delay line matched to the pipeline, which has no valid of its own.

## Interface
- N, 16, data/angle width (signed two's complement)
- STAGE, 16, latency in cycles of the attached vectoring pipeline; delay-line depth
- ANG_PI, 18000, 180° in pipeline angle units (degrees × 100)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  x_in/y_in valid this cycle
- x_in, y_in  in  N  signed input vector
- x_fold, y_fold  out  N  registered folded vector, drives pipeline x_in/y_in
- r_pipe  in  N  pipeline r_out
- ang_pipe  in  N  pipeline angle_out
- out_valid  out  1  r_out/angle_out/quad_out valid
- r_out  out  N  magnitude, registered copy of r_pipe
- angle_out  out  N  signed angle in (−ANG_PI, +ANG_PI]
- quad_out  out  2  quadrant of the original input

## Operation
- Quadrant code: 0 = x≥0,y≥0; 1 = x<0,y≥0; 2 = x<0,y<0; 3 = x≥0,y<0.
- Fold (x_in ≥ 0): x_fold = x_in, y_fold = y_in, flip = 0.
- Fold (x_in < 0): x_fold = −x_in, y_fold = −y_in, flip = 1. Negation of −2^(N−1) saturates to 2^(N−1)−1.
- Fold registers load every cycle in which in_valid = 1. When in_valid = 0 they hold their previous value.
- Delay line: STAGE-deep shift register of {valid, flip, quad}. It shifts every cycle and its head is loaded with {in_valid, flip, quad}. There is no backpressure, and the pipeline is free-running.
- Correction, using the tag at the end of the delay line:
  - flip = 0: a = ang_pipe.
  - flip = 1, quad 1: a = ang_pipe + ANG_PI.
  - flip = 1, quad 2: a = ang_pipe − ANG_PI.
- Arithmetic is N+1 bits wide. If a > ANG_PI, subtract 2·ANG_PI. If a ≤ −ANG_PI, add 2·ANG_PI. The result is then truncated to N bits.
- The output register loads r_out = r_pipe, angle_out = a and quad_out = tag quad only when the tag valid = 1. Otherwise it holds.
- Input (0,0) is quadrant 0 with flip = 0. Its angle is whatever the pipeline produces; no special case.

## Timing
- Fold register: 1 cycle. Pipeline: STAGE cycles. Correction register: 1 cycle. Total in_valid → out_valid latency is STAGE+2 cycles.
- Throughput is 1 vector per cycle. Gaps in in_valid reappear in out_valid with an identical pattern.
- Delay-line tap alignment: the tag entering with x_fold at cycle t+1 is applied to ang_pipe at cycle t+1+STAGE. The registered result appears at t+STAGE+2.
- Reset values (rst low, asynchronous): x_fold, y_fold, r_out, angle_out = 0; quad_out = 0; out_valid = 0; all delay-line entries = 0.
- Reset mid-stream: all in-flight tags are cleared and those vectors are dropped. out_valid stays 0 until STAGE+2 cycles after the first post-reset in_valid.
- Reset release is sampled synchronously by the first clk edge with rst high. A valid presented on that edge is accepted.

## Test plan
- Reset release, then in_valid = 1 with (1000,0): one out_valid pulse exactly STAGE+2 cycles later, angle_out = 0±20, quad_out = 0, r_out within ±2% of 1000.
- (−1000,0): x_fold = 1000, y_fold = 0, angle_out = 18000±20 (never −18000), quad_out = 1. (−1000,−1000): angle_out = −13500±20, quad_out = 2. (1000,−1000): angle_out = −4500±20, quad_out = 3.
- Wrap: force ang_pipe = +30 with a flip/quad-1 tag. angle_out = 18030−36000 = −17970.
- x_in = −32768, y_in = 0: x_fold = 32767, y_fold = 0, quad_out = 1.
- Valid pattern 1,1,0,1,0,0,1: out_valid shows the same pattern delayed STAGE+2 cycles. Outputs hold during invalid slots.
- Assert rst low for 1 cycle while 5 vectors are in flight: out_valid = 0 immediately and stays 0 for those 5 vectors. The next vector emerges STAGE+2 cycles after it is presented.
